r4otf_conv: RTL and testbench

R4OTF_CONV -- requirements
Module: r4otf_conv

---
 rtl/r4_pkg.sv | 28 ++
 rtl/r4otf_conv_if.sv | 27 ++
 rtl/r4otf_step.sv | 33 +++
 rtl/r4otf_conv.sv | 98 +++++++++
 tb/tb_r4otf_conv.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/r4_pkg.sv
// Shared radix-4 signed-digit types, digit limits and converter FSM states.
package r4_pkg;

    localparam int unsigned DIGIT_W = 3;

    typedef logic signed [DIGIT_W-1:0] digit_t;

    localparam int DIGIT_MIN = -3;
    localparam int DIGIT_MAX = 3;

    // The one 3-bit code outside the legal digit set.
    localparam digit_t DIGIT_ILLEGAL = digit_t'(-4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic digit_t sat_digit(input digit_t d);
        return (d < digit_t'(DIGIT_MIN)) ? digit_t'(DIGIT_MIN) : d;
    endfunction

    function automatic logic is_illegal(input digit_t d);
        return d == DIGIT_ILLEGAL;
    endfunction

endpackage

// File: rtl/r4otf_conv_if.sv
// Digit-stream / result bus between a radix-4 digit producer and the converter.
interface r4otf_conv_if
    import r4_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = 2*N+1
) ();

    logic         start;
    logic         valid_in;
    digit_t       d_in;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic         err;

    modport master (
        output start, valid_in, d_in,
        input  busy, done, q, err
    );

    modport slave (
        input  start, valid_in, d_in,
        output busy, done, q, err
    );

endinterface

// File: rtl/r4otf_step.sv
// One on-the-fly conversion step: shift-append a digit into Q and QM.
module r4otf_step
    import r4_pkg::*;
#(
    parameter int unsigned W = 17
) (
    input  logic [W-1:0] q_i,
    input  logic [W-1:0] qm_i,
    input  digit_t       d_i,
    output logic [W-1:0] q_o,
    output logic [W-1:0] qm_o
);

    logic [1:0] q_tail;
    logic [1:0] qm_tail;

    // Negative digits borrow from QM so no carry ever propagates.
    always_comb begin
        q_tail  = 2'(int'(d_i));
        qm_tail = 2'(int'(d_i) + 3);
        q_o     = W'({q_i, q_tail});
        qm_o    = W'({qm_i, qm_tail});
        if (d_i < 0) begin
            q_tail = 2'(int'(d_i) + 4);
            q_o    = W'({qm_i, q_tail});
        end
        if (d_i > 0) begin
            qm_tail = 2'(int'(d_i) - 1);
            qm_o    = W'({q_i, qm_tail});
        end
    end

endmodule

// File: rtl/r4otf_conv.sv
// Radix-4 signed-digit to two's-complement converter, MSD first, on-the-fly.
module r4otf_conv
    import r4_pkg::*;
#(
    parameter int unsigned N = 8,
    parameter int unsigned W = 2*N+1
) (
    input  logic         clk,
    input  logic         reset,
    r4otf_conv_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(N+1);

    state_e           state_q, state_d;
    logic [W-1:0]     q_q, q_d, qm_q, qm_d;
    logic [W-1:0]     q_step, qm_step;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accept_c;
    logic             last_c;
    digit_t           dig_c;

    assign accept_c = (state_q == CONV) && bus.valid_in && !bus.start;
    assign last_c   = accept_c && (cnt_q == CNT_W'(N-1));
    assign dig_c    = sat_digit(bus.d_in);

    r4otf_step #(.W(W)) u_step (
        .q_i  (q_q),
        .qm_i (qm_q),
        .d_i  (dig_c),
        .q_o  (q_step),
        .qm_o (qm_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = CONV;
            CONV:    if (bus.start) state_d = CONV;
                     else if (last_c) state_d = DONE;
            DONE:    state_d = bus.start ? CONV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and status next values; start always wins over a digit.
    always_comb begin
        q_d    = q_q;
        qm_d   = qm_q;
        cnt_d  = cnt_q;
        err_d  = err_q;
        busy_d = (state_d == CONV);
        done_d = (state_d == DONE);
        if (bus.start) begin
            q_d   = '0;
            qm_d  = '1;
            cnt_d = '0;
            err_d = 1'b0;
        end else if (accept_c) begin
            q_d   = q_step;
            qm_d  = qm_step;
            cnt_d = cnt_q + CNT_W'(1);
            if (is_illegal(bus.d_in)) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            qm_q   <= '1;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            qm_q   <= qm_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;

endmodule

// File: tb/tb_r4otf_conv.sv
// Scoreboard bench for r4otf_conv with N = 4, W = 9.
module tb_r4otf_conv;
    import r4_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned W = 2*N+1;

    typedef struct packed {
        logic [W-1:0] q;
        logic         err;
    } exp_t;

    typedef int digs_t [N];

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    r4otf_conv_if #(.N(N), .W(W)) bus ();

    r4otf_conv #(.N(N), .W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Count done pulses just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (bus.done === 1'b1) done_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Exact value sum d_i * 4^(N-i), -4 treated as -3 and flagged.
    function automatic exp_t model(input digs_t d);
        exp_t r;
        int   acc;
        int   v;
        acc   = 0;
        r.err = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            v = d[i];
            if (v == -4) begin
                v     = -3;
                r.err = 1'b1;
            end
            acc = acc * 4 + v;
        end
        r.q = W'(acc);
        return r;
    endfunction

    task automatic do_conv(input digs_t d, input bit gaps, output int lat, output int gap_low);
        int edges;
        int n;
        bus.start    = 1'b1;
        bus.valid_in = 1'b1;
        bus.d_in     = digit_t'(3);
        @(negedge clk);
        edges        = 1;
        gap_low      = 0;
        bus.start    = 1'b0;
        bus.valid_in = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (gaps && i > 0) begin
                bus.valid_in = 1'b0;
                @(negedge clk);
                edges++;
                if (bus.busy !== 1'b1) gap_low++;
            end
            bus.valid_in = 1'b1;
            bus.d_in     = digit_t'(d[i]);
            @(negedge clk);
            edges++;
        end
        bus.valid_in = 1'b0;
        n = 0;
        while (bus.done !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
            edges++;
        end
        lat = (bus.done === 1'b1) ? edges : -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.q !== W'(0)) $display("FAIL reset_q got %h want 000", bus.q); else n_pass++;
        n_checks++; if (bus.err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.err); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        digs_t tbl [5];
        exp_t  e;
        logic [W-1:0] q_hold;
        int lat, gl, d0;
        tbl[0] = '{1, 0, 0, 0};
        tbl[1] = '{1, -3, 0, 0};
        tbl[2] = '{-1, 0, 0, 0};
        tbl[3] = '{3, 3, 3, 3};
        tbl[4] = '{-3, -3, -3, -3};
        for (int k = 0; k < 5; k++) begin
            sb.push_back(model(tbl[k]));
            d0 = done_cnt;
            do_conv(tbl[k], 1'b0, lat, gl);
            e = sb.pop_front();
            n_checks++; if (bus.q !== e.q) $display("FAIL basic%0d_q got %h want %h", k, bus.q, e.q); else n_pass++;
            n_checks++; if (bus.err !== e.err) $display("FAIL basic%0d_err got %b want %b", k, bus.err, e.err); else n_pass++;
            n_checks++; if (lat != 5) $display("FAIL basic%0d_latency got %0d want 5", k, lat); else n_pass++;
            q_hold = bus.q;
            @(negedge clk);
            n_checks++; if (bus.done !== 1'b0) $display("FAIL basic%0d_done_width got %b want 0", k, bus.done); else n_pass++;
            n_checks++; if (bus.q !== e.q) $display("FAIL basic%0d_q_stable got %h want %h", k, bus.q, q_hold); else n_pass++;
            n_checks++; if (done_cnt - d0 != 1) $display("FAIL basic%0d_done_count got %0d want 1", k, done_cnt - d0); else n_pass++;
        end
    endtask

    task automatic test_gaps();
        digs_t d;
        exp_t  e;
        int lat, gl, d0;
        d = '{2, -2, 1, -1};
        sb.push_back(model(d));
        d0 = done_cnt;
        do_conv(d, 1'b1, lat, gl);
        e = sb.pop_front();
        n_checks++; if (bus.q !== e.q) $display("FAIL gaps_q got %h want %h", bus.q, e.q); else n_pass++;
        n_checks++; if (lat != 8) $display("FAIL gaps_latency got %0d want 8", lat); else n_pass++;
        n_checks++; if (gl != 0) $display("FAIL gaps_busy_low got %0d want 0", gl); else n_pass++;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL gaps_done_count got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        digs_t tbl [3];
        exp_t  e;
        int lat, gl, d0;
        tbl[0] = '{0, 1, 2, 3};
        tbl[1] = '{-2, 3, -1, 0};
        tbl[2] = '{3, -3, 3, -3};
        d0 = done_cnt;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(model(tbl[k]));
            do_conv(tbl[k], 1'b0, lat, gl);
            e = sb.pop_front();
            n_checks++; if (bus.q !== e.q) $display("FAIL b2b%0d_q got %h want %h", k, bus.q, e.q); else n_pass++;
            n_checks++; if (lat != 5) $display("FAIL b2b%0d_latency got %0d want 5", k, lat); else n_pass++;
        end
        // Digits offered while idle must be ignored.
        for (int k = 0; k < 3; k++) begin
            bus.valid_in = 1'b1;
            bus.d_in     = digit_t'(k + 1);
            @(negedge clk);
        end
        bus.valid_in = 1'b0;
        n_checks++; if (bus.q !== e.q) $display("FAIL idle_digits_q got %h want %h", bus.q, e.q); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL idle_digits_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (done_cnt - d0 != 3) $display("FAIL b2b_done_count got %0d want 3", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_restart();
        digs_t d;
        exp_t  e;
        int lat, gl, d0;
        d0 = done_cnt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.valid_in = 1'b1;
        bus.d_in     = digit_t'(3);
        @(negedge clk);
        bus.d_in     = digit_t'(-2);
        @(negedge clk);
        d = '{0, 0, 2, -1};
        sb.push_back(model(d));
        do_conv(d, 1'b0, lat, gl);
        e = sb.pop_front();
        n_checks++; if (bus.q !== e.q) $display("FAIL restart_q got %h want %h", bus.q, e.q); else n_pass++;
        n_checks++; if (lat != 5) $display("FAIL restart_latency got %0d want 5", lat); else n_pass++;
        @(negedge clk);
        n_checks++; if (done_cnt - d0 != 1) $display("FAIL restart_done_count got %0d want 1", done_cnt - d0); else n_pass++;
    endtask

    task automatic test_reset_mid();
        digs_t d;
        exp_t  e;
        int lat, gl, d0;
        d0 = done_cnt;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.valid_in = 1'b1;
        bus.d_in     = digit_t'(3);
        @(negedge clk);
        bus.d_in     = digit_t'(2);
        @(negedge clk);
        bus.valid_in = 1'b1;
        bus.d_in     = digit_t'(1);
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.q !== W'(0)) $display("FAIL rstmid_q got %h want 000", bus.q); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL rstmid_done got %b want 0", bus.done); else n_pass++;
        @(negedge clk);
        reset        = 1'b0;
        bus.valid_in = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (done_cnt != d0) $display("FAIL rstmid_no_done got %0d want 0", done_cnt - d0); else n_pass++;
        d = '{0, 0, 0, 1};
        sb.push_back(model(d));
        do_conv(d, 1'b0, lat, gl);
        e = sb.pop_front();
        n_checks++; if (bus.q !== e.q) $display("FAIL rstmid_restart_q got %h want %h", bus.q, e.q); else n_pass++;
    endtask

    task automatic test_err();
        digs_t d;
        exp_t  e;
        int lat, gl;
        d = '{-4, 0, 0, 0};
        sb.push_back(model(d));
        do_conv(d, 1'b0, lat, gl);
        e = sb.pop_front();
        n_checks++; if (bus.q !== e.q) $display("FAIL err_q got %h want %h", bus.q, e.q); else n_pass++;
        n_checks++; if (bus.err !== e.err) $display("FAIL err_flag got %b want %b", bus.err, e.err); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.err !== 1'b1) $display("FAIL err_sticky got %b want 1", bus.err); else n_pass++;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n_checks++; if (bus.err !== 1'b0) $display("FAIL err_clear got %b want 0", bus.err); else n_pass++;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL err_restart_busy got %b want 1", bus.busy); else n_pass++;
    endtask

    task automatic test_random();
        digs_t d;
        exp_t  e;
        bit    g;
        int lat, gl;
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < int'(N); i++)
                d[i] = int'($urandom_range(DIGIT_MAX - DIGIT_MIN, 0)) + DIGIT_MIN;
            g = 1'($urandom_range(1, 0));
            sb.push_back(model(d));
            do_conv(d, g, lat, gl);
            e = sb.pop_front();
            n_checks++; if (bus.q !== e.q) $display("FAIL rand%0d_q got %h want %h", k, bus.q, e.q); else n_pass++;
            n_checks++; if (bus.err !== e.err) $display("FAIL rand%0d_err got %b want %b", k, bus.err, e.err); else n_pass++;
            n_checks++; if (lat != (g ? 8 : 5)) $display("FAIL rand%0d_latency got %0d want %0d", k, lat, g ? 8 : 5); else n_pass++;
        end
    endtask

    initial begin
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.valid_in = 1'b0;
        bus.d_in     = digit_t'(0);
        test_reset();
        test_basic();
        test_gaps();
        test_back_to_back();
        test_restart();
        test_reset_mid();
        test_err();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
